bitstream_writer: RTL and testbench
===================================

Name: bitstream_writer

Overview:
- Serializing transmitter for the configuration bitstream. It is the sending end of the AXI-stream link that configurable tiles (LUTs and similar) consume through their bitstream readers.
- Captures a parallel configuration word on `start`, then emits it LSB-first as a packet of AXI-stream beats, with `tlast` on the final beat.
- Used by the top-level config sequencer and by testbenches to drive tile configuration.

Parameters:
- NUM_BITS_TO_WRITE, 16, total payload bits per packet (≥1).
- BEAT_WIDTH, 1, payload bits per beat; must equal the tdata width of the connected stream (≥1).
- NUM_BEATS, ceil(NUM_BITS_TO_WRITE / BEAT_WIDTH), derived; do not override.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request to send; sampled only in IDLE.
- bits  input  NUM_BITS_TO_WRITE  payload; captured in the cycle `start` is accepted.
- bitstream  axi_stream_if.master  -  drives tvalid, tdata[BEAT_WIDTH-1:0], tlast; samples tready.
- busy  output  1  high from the cycle after `start` is accepted until the final handshake, inclusive.
- done  output  1  one-cycle pulse in the cycle after the final beat handshake.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, beat counter=0, shift register=0.
  - tvalid=0, tlast=0, tdata=0, busy=0, done=0.
  - Reset mid-packet aborts the packet immediately. No further beats are sent and no done pulse occurs.
- States: IDLE, SEND, DONE.
- IDLE:
  - tvalid=0.
  - If start=1: load shift register with `bits`, zero-padded to NUM_BEATS*BEAT_WIDTH. Set counter=0. Go to SEND.
- SEND:
  - tvalid=1, busy=1.
  - tdata = shift_reg[BEAT_WIDTH-1:0].
  - tlast = (counter == NUM_BEATS-1).
  - On handshake (tvalid & tready):
    - If this is the last beat, go to DONE.
    - Otherwise shift right by BEAT_WIDTH (zero fill), increment counter, and stay in SEND.
  - Without a handshake, tvalid, tdata and tlast hold stable; no beat is dropped or repeated.
  - `start` is ignored while in SEND.
- DONE:
  - done=1, busy=0, tvalid=0.
  - Return to IDLE unconditionally. `start` is not accepted in DONE.
- Latency:
  - First beat is valid 1 cycle after `start` is accepted.
  - With tready held at 1, a packet takes NUM_BEATS cycles in SEND, then done pulses.
  - Minimum start-to-start spacing is NUM_BEATS+2 cycles.
- Padding: the final partial beat carries zeros in the bits above the payload.
- Counter: width clog2(NUM_BEATS) with a minimum of 1 bit. It never wraps within a packet; it is reset on each start.
- tready may be asserted at any time. It has no effect outside SEND.
- No combinational path from tready to tvalid or tdata. All outputs are registered or decoded from state.

Test Plan:
- Basic send: NUM_BITS_TO_WRITE=8, BEAT_WIDTH=1, bits=8'hA5, tready=1 → tvalid high 8 cycles. tdata sequence 1,0,1,0,0,1,0,1. tlast only on the 8th beat. done pulses in the cycle after. busy high exactly 8 cycles.
- Back-pressure: same config, tready toggling 1,0,0,1,… → each beat is held stable while tready=0. The sequence is identical to the basic case, with no duplicates. done comes one cycle after the 8th handshake.
- Padding: NUM_BITS_TO_WRITE=10, BEAT_WIDTH=4, bits=10'h2B7 → 3 beats, tdata 4'h7, 4'hB, 4'h2, with tlast on the third.
- Start while busy: assert start with bits=8'hFF during beat 3 of the 8'hA5 packet → the packet continues as 8'hA5. No restart and no second packet.
- Reset mid-packet: rst_n=0 after beat 4 → next cycle tvalid=0, busy=0, done=0. A subsequent start with 8'h3C sends a full, correct packet from beat 0.
- Back-to-back: start held high continuously → packets separated by exactly the DONE and IDLE cycles. The second packet carries the `bits` value present in the IDLE cycle.

Source files
------------

// File: rtl/bitstream_writer_if.sv
// AXI-stream link carrying configuration beats from a bitstream writer to tile readers.
interface axi_stream_if #(
    parameter int DATA_WIDTH = 1
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/bitstream_writer.sv
// Serializes a parallel configuration word LSB-first into AXI-stream beats,
// flagging the final beat with tlast and pulsing done once the packet is out.
module bitstream_writer #(
    parameter int NUM_BITS_TO_WRITE = 16,
    parameter int BEAT_WIDTH        = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [NUM_BITS_TO_WRITE-1:0] bits,
    axi_stream_if.master                 bitstream,
    output logic                         busy,
    output logic                         done,
    output logic [1:0]                   state_dbg
);
    localparam int NUM_BEATS = (NUM_BITS_TO_WRITE + BEAT_WIDTH - 1) / BEAT_WIDTH;
    localparam int PAD_W     = NUM_BEATS * BEAT_WIDTH;
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [PAD_W-1:0]   shift_reg, shift_next;
    logic [PAD_W-1:0]   bits_padded;

    always_comb begin
        bits_padded = '0;
        bits_padded[NUM_BITS_TO_WRITE-1:0] = bits;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            shift_reg <= shift_next;
        end
    end

    // A beat transfers on a rising edge where tvalid and tready are both high.
    // tvalid, tdata and tlast depend only on registered state, so while tready
    // is low they hold steady and tvalid never drops before the transfer.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        shift_next = shift_reg;
        case (state)
            IDLE: begin
                if (start) begin
                    shift_next = bits_padded;
                    cnt_next   = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (bitstream.tready) begin
                    if (cnt == LAST_CNT) begin
                        state_next = DONE;
                    end else begin
                        shift_next = shift_reg >> BEAT_WIDTH;
                        cnt_next   = cnt + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bitstream.tvalid = (state == SEND);
    assign bitstream.tdata  = shift_reg[BEAT_WIDTH-1:0];
    assign bitstream.tlast  = (state == SEND) && (cnt == LAST_CNT);
    assign busy             = (state == SEND);
    assign done             = (state == DONE);
    assign state_dbg        = state;
endmodule

// File: tb/tb_bitstream_writer.sv
// Bench for bitstream_writer: an 8x1 instance under randomized back-pressure
// against a beat queue, and a 10x4 instance driven from a padding vector table.
module tb_bitstream_writer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start8;
    logic [7:0] bits8;
    logic       busy8, done8;
    logic [1:0] st8;
    logic       start10;
    logic [9:0] bits10;
    logic       busy10, done10;
    logic [1:0] st10;

    axi_stream_if #(.DATA_WIDTH(1)) s8 ();
    axi_stream_if #(.DATA_WIDTH(4)) s10 ();

    bitstream_writer #(.NUM_BITS_TO_WRITE(8), .BEAT_WIDTH(1)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start8),
        .bits      (bits8),
        .bitstream (s8),
        .busy      (busy8),
        .done      (done8),
        .state_dbg (st8)
    );

    bitstream_writer #(.NUM_BITS_TO_WRITE(10), .BEAT_WIDTH(4)) u_dut10 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start10),
        .bits      (bits10),
        .bitstream (s10),
        .busy      (busy10),
        .done      (done10),
        .state_dbg (st10)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard for the 8-bit instance: each entry is {tlast, tdata}.
    logic [1:0] exp_q[$];

    task automatic push8(input logic [7:0] b);
        logic [1:0] e;
        for (int k = 0; k < 8; k++) begin
            e = {(k == 7), b[k]};
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // tready pattern for the 8-bit link: 0 = always, 1 = 1,0,0 repeating, 2 = random
    int rdy_mode = 0;
    initial begin
        int phase;
        phase = 0;
        s8.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    s8.tready = (phase == 0);
                    phase = (phase + 1) % 3;
                end
                2: s8.tready = 1'($urandom_range(0, 1));
                default: s8.tready = 1'b1;
            endcase
        end
    end

    // Monitor: beats in order, hold under back-pressure, done one cycle after the last handshake.
    initial begin
        logic       prev_v, prev_r, prev_d, prev_l, prev_hs_last;
        logic [1:0] e;
        prev_v = 0; prev_r = 0; prev_d = 0; prev_l = 0; prev_hs_last = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 0;
                prev_hs_last = 0;
            end else begin
                check("done8_timing", 32'(done8), 32'(prev_hs_last));
                check("busy8_vs_tvalid", 32'(busy8), 32'(s8.tvalid));
                check("tvalid8_vs_pending", 32'(s8.tvalid), 32'(exp_q.size() != 0));
                if (prev_v && !prev_r) begin
                    check("hold_tvalid", 32'(s8.tvalid), 32'd1);
                    check("hold_tdata", 32'(s8.tdata), 32'(prev_d));
                    check("hold_tlast", 32'(s8.tlast), 32'(prev_l));
                end
                if (s8.tvalid && s8.tready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat8_data", 32'(s8.tdata), 32'(e[0]));
                    check("beat8_last", 32'(s8.tlast), 32'(e[1]));
                end
                prev_v = s8.tvalid;
                prev_r = s8.tready;
                prev_d = s8.tdata;
                prev_l = s8.tlast;
                prev_hs_last = s8.tvalid && s8.tready && s8.tlast;
            end
        end
    end

    task automatic start8_pkt(input logic [7:0] b);
        start8 = 1'b1;
        bits8  = b;
        tick();
        start8 = 1'b0;
        bits8  = 8'($urandom);
        push8(b);
    endtask

    // Ticks until done is seen (counting busy cycles), then steps into IDLE.
    task automatic run_until_done8(input int budget, output int busy_cycles);
        logic got;
        got = 0;
        busy_cycles = 0;
        for (int k = 0; k < budget && !got; k++) begin
            if (done8) got = 1;
            else begin
                if (busy8) busy_cycles++;
                tick();
            end
        end
        check("done8_reached", 32'(got), 32'd1);
        if (got) tick();
    endtask

    typedef struct {
        logic [9:0] bits;
        logic [3:0] beat [3];
        logic       stall;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int   bc;
        logic [7:0] b;

        vecs[0] = '{bits: 10'h2B7, beat: '{4'h7, 4'hB, 4'h2}, stall: 1'b0};
        vecs[1] = '{bits: 10'h3FF, beat: '{4'hF, 4'hF, 4'h3}, stall: 1'b0};
        vecs[2] = '{bits: 10'h155, beat: '{4'h5, 4'h5, 4'h1}, stall: 1'b1};
        vecs[3] = '{bits: 10'h2AA, beat: '{4'hA, 4'hA, 4'h2}, stall: 1'b0};
        vecs[4] = '{bits: 10'h000, beat: '{4'h0, 4'h0, 4'h0}, stall: 1'b1};

        rst_n = 1'b0; start8 = 1'b0; bits8 = 8'h00; start10 = 1'b0; bits10 = 10'h000;
        s10.tready = 1'b1;
        tick();
        tick();
        check("rst_tvalid8", 32'(s8.tvalid), 32'd0);
        check("rst_tlast8",  32'(s8.tlast),  32'd0);
        check("rst_tdata8",  32'(s8.tdata),  32'd0);
        check("rst_busy8",   32'(busy8),     32'd0);
        check("rst_done8",   32'(done8),     32'd0);
        check("rst_tvalid10", 32'(s10.tvalid), 32'd0);
        check("rst_tdata10",  32'(s10.tdata),  32'd0);
        check("rst_busy10",   32'(busy10),     32'd0);
        rst_n = 1'b1;
        tick();

        // Basic packet with tready held high
        start8_pkt(8'hA5);
        run_until_done8(40, bc);
        check("basic_busy_cycles", 32'(bc), 32'd8);

        // Back-pressure 1,0,0 pattern
        rdy_mode = 1;
        start8_pkt(8'hA5);
        run_until_done8(80, bc);
        rdy_mode = 0;
        tick();
        tick();

        // start with new bits while beat 3 is on the wire is ignored
        start8_pkt(8'hA5);
        tick();
        tick();
        start8 = 1'b1;
        bits8  = 8'hFF;
        tick();
        start8 = 1'b0;
        run_until_done8(40, bc);
        check("busy_start_remaining", 32'(bc), 32'd5);
        repeat (12) tick();
        check("busy_start_no_restart", 32'(busy8), 32'd0);

        // Reset after four beats aborts the packet
        start8_pkt(8'hA5);
        repeat (4) tick();
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        check("abort_tvalid", 32'(s8.tvalid), 32'd0);
        check("abort_busy",   32'(busy8),     32'd0);
        check("abort_done",   32'(done8),     32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("abort_no_done", 32'(done8), 32'd0);
        start8_pkt(8'h3C);
        run_until_done8(40, bc);
        check("after_abort_busy_cycles", 32'(bc), 32'd8);

        // start held high: acceptances every NUM_BEATS+2 = 10 cycles
        for (int i = 0; i < 30; i++) begin
            b = 8'($urandom);
            bits8  = b;
            start8 = 1'b1;
            tick();
            if (i % 10 == 0) push8(b);
        end
        start8 = 1'b0;
        repeat (4) tick();
        check("b2b_drained", 32'(exp_q.size()), 32'd0);

        // Random packets under random back-pressure
        rdy_mode = 2;
        for (int p = 0; p < 10; p++) begin
            start8_pkt(8'($urandom));
            run_until_done8(300, bc);
            check("rand_busy_min", 32'(bc >= 8), 32'd1);
            repeat ($urandom_range(0, 3)) tick();
        end
        rdy_mode = 0;
        tick();

        // Padding table on the 10-bit / 4-bit-beat instance
        for (int v = 0; v < 5; v++) begin
            start10 = 1'b1;
            bits10  = vecs[v].bits;
            tick();
            start10 = 1'b0;
            bits10  = 10'($urandom);
            for (int k = 0; k < 3; k++) begin
                if (vecs[v].stall && k == 1) begin
                    s10.tready = 1'b0;
                    repeat (2) begin
                        tick();
                        check("pad_hold_tvalid", 32'(s10.tvalid), 32'd1);
                        check("pad_hold_tdata",  32'(s10.tdata),  32'(vecs[v].beat[1]));
                    end
                    s10.tready = 1'b1;
                end
                check("pad_tvalid", 32'(s10.tvalid), 32'd1);
                check("pad_busy",   32'(busy10),     32'd1);
                check("pad_tdata",  32'(s10.tdata),  32'(vecs[v].beat[k]));
                check("pad_tlast",  32'(s10.tlast),  32'(k == 2));
                tick();
            end
            check("pad_done",        32'(done10),     32'd1);
            check("pad_done_tvalid", 32'(s10.tvalid), 32'd0);
            check("pad_done_busy",   32'(busy10),     32'd0);
            tick();
            check("pad_done_pulse", 32'(done10), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
